brick_hit_arbiter: RTL
======================

# brick_hit_arbiter

Serializes brick-hit requests from several bullet/shot sources into the single-port collision interface of the brick matrix (`collision`, `brickCollision1X`, `brickCollision1Y`). The brick matrix processes at most one hit per collision assertion and needs `collision` low for at least one cycle before it accepts another. This block therefore latches each requester's hit coordinates and grants the requesters round-robin. It issues exactly one single-cycle collision pulse per accepted hit, followed by a mandatory low gap. It sits between the per-object collision detectors and the brick matrix in the VGA game datapath.

## Interface
Parameters:
- `NUM_REQ`, 4: number of hit requesters (player and enemy shots).
- `COLS`, 17: brick columns; valid X is 0..COLS-1.
- `ROWS`, 14: brick rows; valid Y is 0..ROWS-1.
- `GAP_CYCLES`, 1: cycles `collision` is held low after each pulse; must be ≥1.

Ports:
- `clk` in 1: single clock, all logic on rising edge.
- `reset` in 1: synchronous, active-high reset.
- `hitReq` in NUM_REQ: per-requester hit strobe; sampled every edge.
- `hitX` in NUM_REQ×5: brick column of the hit, valid with `hitReq[i]`.
- `hitY` in NUM_REQ×4: brick row of the hit, valid with `hitReq[i]`.
- `hitAck` out NUM_REQ: one-cycle pulse; requester i's hit is being issued.
- `hitDrop` out NUM_REQ: one-cycle pulse; requester i's strobe was discarded.
- `collision` out 1: to brick matrix; high for exactly one cycle per issued hit.
- `brickCollision1X` out 5: column of the issued hit.
- `brickCollision1Y` out 4: row of the issued hit.
- `busy` out 1: high when any hit is pending or the FSM is not in IDLE.

## Operation
- Per-requester pending slot: `pend[i]`, `pX[i]`, `pY[i]`.
- A strobe is accepted at an edge when all of these hold:
  - `hitReq[i]` is 1;
  - `hitX[i] < COLS` and `hitY[i] < ROWS`;
  - `pend[i]` is 0, or requester i is granted at that same edge.
- On accept, `pend[i]` is set to 1 and `pX[i]`/`pY[i]` capture `hitX[i]`/`hitY[i]`.
- If `hitReq[i]` is 1 but the strobe is not accepted (coordinate out of range, or slot occupied and not being granted), `hitDrop[i]` is 1 in the next cycle. Stored coordinates are unchanged.
- FSM states and transitions:
  - IDLE: if any `pend` is set, grant and go to ISSUE.
  - ISSUE: always go to GAP.
  - GAP: count GAP_CYCLES cycles. On the last one, grant and go to ISSUE if any `pend` is set; otherwise go to IDLE.
- Grant selects the first set `pend[j]` scanning from `ptr`, `ptr+1`, … modulo NUM_REQ. At the grant edge:
  - `brickCollision1X/Y` load `pX[g]`/`pY[g]`;
  - `pend[g]` clears, unless re-accepted at that same edge;
  - `ptr` becomes (g+1) mod NUM_REQ.
- `collision` is 1 only in ISSUE. `hitAck[g]` is 1 in the same cycle as `collision`.
- `brickCollision1X/Y` hold their value through ISSUE and GAP until the next grant. They stay stable for at least one cycle after `collision` falls.
- No other output bit changes while `collision` is 1.

## Timing
- Reset values: FSM=IDLE, `pend`=0, `ptr`=0, `collision`=0, `brickCollision1X`=0, `brickCollision1Y`=0, `hitAck`=0, `hitDrop`=0, `busy`=0.
- Reset asserted mid-operation: at the next edge all pending hits are discarded and all outputs take their reset values. No acks or drops are reported for the discarded hits.
- All outputs are registered.
- Latency from idle: `hitReq` sampled at edge E0 → `pend` set at E0 → grant at E1 → `collision`=1 in the cycle after E1 → `collision`=0 after E2.
- Throughput: one hit per 1+GAP_CYCLES cycles while requests are queued; there is no idle cycle between GAP and the next ISSUE.
- `collision` never stays high for more than one consecutive cycle.
- Simultaneous requests are queued and issued in round-robin order.
- A requester strobing every cycle is served once per round. Each strobe arriving while its slot is full and not being granted produces one `hitDrop` pulse.
- `busy` is registered: it reflects `pend` and FSM state after each edge.

## Test plan
- **Single hit:** reset, then one-cycle `hitReq[0]` with X=5, Y=3.
  - `collision`=1 for exactly 1 cycle, 2 cycles after the strobe edge, with X=5, Y=3.
  - `hitAck[0]` coincident with `collision`.
  - `busy` falls once the FSM returns to IDLE.
- **Four simultaneous hits:** all four requesters strobe in one cycle, coordinates (1,1), (2,2), (3,3), (4,4).
  - Four pulses issued in order 0,1,2,3, spaced 2 cycles apart (GAP_CYCLES=1).
  - `collision` is low between pulses.
- **Round-robin fairness:** requesters 0 and 2 strobe every cycle for 20 cycles.
  - Grants alternate 0,2,0,2.
  - `hitDrop[0]` and `hitDrop[2]` pulse on each strobe that lands on a full slot.
- **Out-of-range:** `hitReq[1]` with X=17, Y=0, then with X=0, Y=14.
  - Each gives `hitDrop[1]` pulse, no `collision`, `busy` stays 0.
- **Back-to-back same requester:** `hitReq[3]` strobes at the grant edge of its previous hit.
  - New hit accepted, no drop.
  - Issued as the next pulse after the gap.
- **Reset mid-stream:** 3 hits pending, `reset` asserted during ISSUE.
  - After the next edge all outputs are 0.
  - No further `collision` or `hitAck` until new requests arrive.

Source files
------------

// File: rtl/brick_hit_arbiter.sv
// Round-robin serializer of brick-hit requests onto the single-port brick-matrix
// collision interface: one-cycle collision pulse per hit, then a mandatory low gap.
module brick_hit_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int COLS       = 17,
  parameter int ROWS       = 14,
  parameter int GAP_CYCLES = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      hitReq,
  input  logic [NUM_REQ-1:0][4:0] hitX,
  input  logic [NUM_REQ-1:0][3:0] hitY,
  output logic [NUM_REQ-1:0]      hitAck,
  output logic [NUM_REQ-1:0]      hitDrop,
  output logic                    collision,
  output logic [4:0]              brickCollision1X,
  output logic [3:0]              brickCollision1Y,
  output logic                    busy
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [4:0] COLS_L = 5'(COLS);
  localparam logic [3:0] ROWS_L = 4'(ROWS);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, GAP = 2'd2} state_t;

  state_t                  state, state_next;
  logic [NUM_REQ-1:0]      pend, pend_next, accept, drop_now, grant_onehot;
  logic [NUM_REQ-1:0][4:0] px;
  logic [NUM_REQ-1:0][3:0] py;
  logic [IW-1:0]           ptr, ptr_next, grant_idx;
  logic [CW-1:0]           gap_cnt;
  logic                    any_pend, gap_last, grant_now;

  // Round-robin pick: first pending slot at or after ptr, wrapping modulo NUM_REQ.
  always_comb begin
    logic       found;
    logic [IW-1:0] idx;
    int         sum;
    found     = 1'b0;
    grant_idx = '0;
    idx       = '0;
    sum       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = int'(ptr) + k;
      if (sum >= NUM_REQ) begin
        sum = sum - NUM_REQ;
      end else begin
        sum = sum;
      end
      idx = IW'(sum);
      if (!found && pend[idx]) begin
        grant_idx = idx;
        found     = 1'b1;
      end else begin
        found = found;
      end
    end
  end

  assign any_pend     = |pend;
  assign gap_last     = (state == GAP) && (gap_cnt == CW'(GAP_CYCLES - 1));
  assign grant_now    = any_pend && ((state == IDLE) || gap_last);
  assign grant_onehot = grant_now ? (NUM_REQ'(1) << grant_idx) : '0;
  assign ptr_next     = (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

  // A strobe is taken if in range and its slot is free or being granted right now.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
    assign accept[i] = hitReq[i] && (hitX[i] < COLS_L) && (hitY[i] < ROWS_L) &&
                       (!pend[i] || grant_onehot[i]);

    // Coordinate capture for slot i.
    always_ff @(posedge clk) begin
      if (reset) begin
        px[i] <= 5'd0;
        py[i] <= 4'd0;
      end else if (accept[i]) begin
        px[i] <= hitX[i];
        py[i] <= hitY[i];
      end else begin
        px[i] <= px[i];
        py[i] <= py[i];
      end
    end
  end

  assign drop_now  = hitReq & ~accept;
  assign pend_next = (pend & ~grant_onehot) | accept;

  // Next FSM state.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = grant_now ? ISSUE : IDLE;
      ISSUE:   state_next = GAP;
      GAP: begin
        if (gap_last) begin
          state_next = grant_now ? ISSUE : IDLE;
        end else begin
          state_next = GAP;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM, pending flags, pointer and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      pend             <= '0;
      ptr              <= '0;
      gap_cnt          <= '0;
      collision        <= 1'b0;
      hitAck           <= '0;
      hitDrop          <= '0;
      brickCollision1X <= 5'd0;
      brickCollision1Y <= 4'd0;
      busy             <= 1'b0;
    end else begin
      state     <= state_next;
      pend      <= pend_next;
      collision <= grant_now;
      hitAck    <= grant_onehot;
      hitDrop   <= drop_now;
      busy      <= (|pend_next) || (state_next != IDLE);
      if (state == GAP) begin
        gap_cnt <= gap_cnt + 1'b1;
      end else begin
        gap_cnt <= '0;
      end
      if (grant_now) begin
        brickCollision1X <= px[grant_idx];
        brickCollision1Y <= py[grant_idx];
        ptr              <= ptr_next;
      end else begin
        brickCollision1X <= brickCollision1X;
        brickCollision1Y <= brickCollision1Y;
        ptr              <= ptr;
      end
    end
  end

endmodule
